// File: rtl/div_pkg.sv
// Shared constants for the multicycle signed divider: state encoding,
// default operand width and the start-to-done latency.
package div_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;

    typedef logic [1:0] div_state_t;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;
    localparam logic [1:0] DIV_DONE = 2'd3;

endpackage

// File: rtl/div_unit_if.sv
// Start/done handshake and operand/result bus between the control unit
// (master) and the divider (slave).
interface div_unit_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude, select the result.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // Trial subtraction on WIDTH+1 bits; its MSB is the borrow/sign.
    always_comb begin
        shifted_s = {rem_i, quo_i[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dmag_i};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_o = trial_s[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted_s[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (restoring, one quotient bit per cycle, then sign fix).
// Optional macro DIV_ZERO_TRAP_EN: zero divisor skips straight to DONE, hi/lo untouched.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic       clk,
    input logic       reset,
    div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] step_rem_s;
    logic [WIDTH-1:0] step_quo_s;
    logic [WIDTH-1:0] dividend_mag_s;
    logic [WIDTH-1:0] divisor_mag_s;
    logic             trap_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dmag_i (dmag_q),
        .rem_o  (step_rem_s),
        .quo_o  (step_quo_s)
    );

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
    always_comb begin
        if (bus.dividend[WIDTH-1]) begin
            dividend_mag_s = {WIDTH{1'b0}} - bus.dividend;
        end else begin
            dividend_mag_s = bus.dividend;
        end
        if (bus.divisor[WIDTH-1]) begin
            divisor_mag_s = {WIDTH{1'b0}} - bus.divisor;
        end else begin
            divisor_mag_s = bus.divisor;
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    assign trap_s = (bus.divisor == {WIDTH{1'b0}});
`else
    assign trap_s = 1'b0;
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dmag_d     = dmag_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (bus.start && trap_s) begin
                    state_d    = DIV_DONE;
                    div_zero_d = 1'b1;
                    done_d     = 1'b1;
                end else if (bus.start) begin
                    state_d   = DIV_CALC;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    rem_d     = {WIDTH{1'b0}};
                    quo_d     = dividend_mag_s;
                    dmag_d    = divisor_mag_s;
                    neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    neg_rem_d = bus.dividend[WIDTH-1];
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_CALC: begin
                rem_d = step_rem_s;
                quo_d = step_quo_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(0)) begin
                    state_d = DIV_FIX;
                end else begin
                    state_d = DIV_CALC;
                end
            end
            DIV_FIX: begin
                lo_d       = neg_quo_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
                hi_d       = neg_rem_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
                div_zero_d = (dmag_q == {WIDTH{1'b0}});
                done_d     = 1'b1;
                state_d    = DIV_DONE;
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
        busy_d = (state_d != DIV_IDLE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            rem_q      <= {WIDTH{1'b0}};
            quo_q      <= {WIDTH{1'b0}};
            dmag_q     <= {WIDTH{1'b0}};
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dmag_q     <= dmag_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus randomized
// operands checked against a plain-arithmetic signed division model.
module tb_div_unit;
    import div_pkg::*;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_lo = 32'd0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] a_v, b_v;
    exp_t        sb_q[$];
    exp_t        mon_e;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference: signed truncating division; zero divisor per its documented result.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, q, r;
        logic [31:0] qmag, rmag;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            e.dz = 1'b1;
`ifdef DIV_ZERO_TRAP_EN
            e.lo  = last_lo;
            e.hi  = last_hi;
            e.due = 1;
`else
            qmag = 32'hFFFF_FFFF;
            r    = (sa < 0) ? -sa : sa;
            rmag = r[31:0];
            e.lo  = (sa < 0) ? (32'd0 - qmag) : qmag;
            e.hi  = (sa < 0) ? (32'd0 - rmag) : rmag;
            e.due = DIV_LATENCY;
`endif
        end else begin
            q     = sa / sb;
            r     = sa % sb;
            e.lo  = q[31:0];
            e.hi  = r[31:0];
            e.dz  = 1'b0;
            e.due = DIV_LATENCY;
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(a, b);
        last_lo = e.lo;
        last_hi = e.hi;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.due = cyc + e.due;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || sb_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("lo", bus.lo, mon_e.lo);
                check("hi", bus.hi, mon_e.hi);
                check("div_zero", {31'd0, bus.div_zero}, {31'd0, mon_e.dz});
                check("latency", cyc, mon_e.due);
            end
        end
    end

    initial begin
        int bad;
        bus.start = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;

        // 100/7 with busy window check over cycles 1..34
        issue(32'd100, 32'd7);
        bad = 0;
        for (int k = 1; k <= DIV_LATENCY; k++) begin
            if (bus.busy !== 1'b1) bad++;
            @(negedge clk);
        end
        check("busy_window_misses", bad, 32'd0);
        check("busy_after_done", {31'd0, bus.busy}, 32'd0);
        wait_idle();

        issue(-32'sd100, 32'd7);          wait_idle();
        issue(32'd100, -32'sd7);          wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        issue(32'h8000_0000, 32'd1);      wait_idle();
        issue(32'd100, 32'd7);            wait_idle();
        issue(32'd7, 32'd0);              wait_idle();
        issue(-32'sd7, 32'd0);            wait_idle();

        // start pulses at cycles 5 and 34 of a run must be ignored
        issue(32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (28) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        check("ignored_start_idle", {31'd0, bus.busy}, 32'd0);
        wait_idle();

        // reset at cycle 10 aborts the run
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        last_lo = 32'd0;
        last_hi = 32'd0;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'd9, 32'd3);
        wait_idle();

        // randomized operands with corner-biased divisors
        for (int i = 0; i < 40; i++) begin
            a_v = $urandom;
            b_v = $urandom;
            case ($urandom_range(0, 5))
                0: b_v = 32'd0;
                1: begin
                    a_v = 32'h8000_0000;
                    if ($urandom_range(0, 1) == 0) b_v = 32'hFFFF_FFFF;
                end
                2: begin
                    b_v = 32'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 0) b_v = 32'd0 - b_v;
                end
                3: a_v = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            issue(a_v, b_v);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
